l2_mshr_alloc: RTL and testbench
================================

Name: l2_mshr_alloc

Overview:
- Owns the L2 MSHR entries.
- Grants requests for a free entry and accepts releases of specific entries.
- Reports the free-entry count `mshr_cnt` and a per-entry busy bitmap.
- Provides a drain handshake: the flush path uses it to stall allocation until every MSHR has retired.
- Sits between the L2 request FSM (allocate side) and the response/writeback path (release side).

Parameters:
- N_MSHR, 4, number of MSHR entries (at least 2).
- MSHR_BITS, 2, index width, equal to clog2(N_MSHR).
- MSHR_BITS_P1, 3, count width, equal to MSHR_BITS+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- alloc_req  in  1  request for one free MSHR this cycle.
- alloc_gnt  out  1  grant; combinational; allocation takes effect at the clock edge.
- alloc_idx  out  MSHR_BITS  lowest-numbered free entry; meaningful only when alloc_gnt=1.
- rel_valid  in  1  release strobe.
- rel_idx  in  MSHR_BITS  entry being released.
- rel_err  out  1  one-cycle registered pulse: the previous cycle released a non-busy entry.
- drain_req  in  1  level request to drain; held until drain_done is seen.
- drain_done  out  1  registered; high while drained and drain_req is still high.
- mshr_busy  out  N_MSHR  registered busy bitmap; bit i set means entry i is allocated.
- mshr_cnt  out  MSHR_BITS_P1  registered free count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - mshr_busy=0, mshr_cnt=N_MSHR, rel_err=0, state=RUN, drain_done=0.
  - Any concurrent alloc or release is discarded.
- free_any = |(~mshr_busy), computed from registered state only. A release does not bypass into a same-cycle grant.
- alloc_idx = priority encode, lowest index first, of ~mshr_busy. When no entry is free, alloc_idx=0.
- alloc_gnt = alloc_req & free_any & (state==RUN) & ~drain_req.
- At each clock edge:
  - busy_next = (mshr_busy | (alloc_gnt ? onehot(alloc_idx) : 0)) & ~(rel_ok ? onehot(rel_idx) : 0).
  - rel_ok = rel_valid & mshr_busy[rel_idx].
  - rel_err_next = rel_valid & ~mshr_busy[rel_idx].
- An invalid release (entry not busy) changes neither mshr_busy nor mshr_cnt.
- Count update:
  - mshr_cnt_next = mshr_cnt - alloc_gnt + rel_ok.
  - Grant and valid release in the same cycle leave the count unchanged.
  - Invariant every cycle: mshr_cnt == N_MSHR - popcount(mshr_busy).
  - The count never goes below 0 or above N_MSHR.
- Same-cycle grant and release: the granted entry is free, so it cannot equal a valid rel_idx. If rel_idx equals alloc_idx, that release is an error and the grant still proceeds.
- Full: with mshr_busy all ones, alloc_gnt=0. A release in that cycle makes the entry grantable from the next cycle.
- State machine (state encoding RUN/DRAIN/DONE):
  - RUN: drain_req=1 goes to DRAIN.
  - DRAIN: allocation blocked; releases accepted. Goes to DONE when the registered mshr_busy==0.
  - DONE: drain_done=1, allocation still blocked. drain_req=0 returns to RUN, with drain_done=0 in that RUN cycle.
  - Deasserting drain_req while in DRAIN returns to RUN without passing through DONE.
- Drain latency: with drain_req rising at cycle t and busy already 0, state=DRAIN at t+1 and drain_done=1 at t+2.
- Reset in any state returns to RUN with the reset values above.

Decomposition:
- Shared package (spandex_types): typedef enum l2_mshr_alloc_state_t {RUN, DRAIN, DONE}.
- N_MSHR / MSHR_BITS / MSHR_BITS_P1 come from spandex_consts and feed the parameter defaults.
- One sub-module: l2_mshr_prio_enc, a parameterised lowest-set-bit priority encoder with outputs idx and any.

Test Plan:
- Reset, then alloc_req=1 for 4 cycles -> alloc_idx 0,1,2,3 with gnt=1 each cycle; mshr_busy=4'b1111 and mshr_cnt=0 after cycle 4; 5th cycle gnt=0.
- Full, rel_valid=1 rel_idx=2 with alloc_req=1 -> gnt=0 that cycle; next cycle gnt=1, alloc_idx=2, mshr_cnt goes 1 then 0.
- busy=4'b0011, same cycle alloc_req=1 and release idx 0 -> alloc_idx=2, busy=4'b0110, mshr_cnt stays 2.
- busy=4'b0001, release idx 3 -> rel_err=1 for exactly one cycle; busy and mshr_cnt unchanged.
- busy=4'b0101, drain_req held high, alloc_req=1 -> gnt=0 throughout; release 0 then 2 -> drain_done=1 one cycle after busy reads 0; drop drain_req -> RUN, gnt resumes with alloc_idx=0.
- Assert rst mid-DRAIN with busy=4'b1000 -> next cycle busy=0, mshr_cnt=4, drain_done=0, state=RUN.

Source files
------------

// File: rtl/l2_mshr_alloc_pkg.sv
// Shared constants and types for the L2 MSHR allocator.
// Holds the default entry count/widths and the drain state encoding.
package l2_mshr_alloc_pkg;

    localparam int L2_N_MSHR        = 4;
    localparam int L2_MSHR_BITS     = $clog2(L2_N_MSHR);
    localparam int L2_MSHR_BITS_P1  = L2_MSHR_BITS + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } l2_mshr_alloc_state_t;

endpackage

// File: rtl/l2_mshr_alloc_if.sv
// Allocate/release/drain bundle between the L2 request FSM, the response path and the MSHR owner.
interface l2_mshr_alloc_if
    import l2_mshr_alloc_pkg::*;
#(
    parameter int N_MSHR       = L2_N_MSHR,
    parameter int MSHR_BITS    = L2_MSHR_BITS,
    parameter int MSHR_BITS_P1 = L2_MSHR_BITS_P1
);

    logic                    alloc_req;
    logic                    alloc_gnt;
    logic [MSHR_BITS-1:0]    alloc_idx;
    logic                    rel_valid;
    logic [MSHR_BITS-1:0]    rel_idx;
    logic                    rel_err;
    logic                    drain_req;
    logic                    drain_done;
    logic [N_MSHR-1:0]       mshr_busy;
    logic [MSHR_BITS_P1-1:0] mshr_cnt;

    modport master (
        output alloc_req, rel_valid, rel_idx, drain_req,
        input  alloc_gnt, alloc_idx, rel_err, drain_done, mshr_busy, mshr_cnt
    );

    modport slave (
        input  alloc_req, rel_valid, rel_idx, drain_req,
        output alloc_gnt, alloc_idx, rel_err, drain_done, mshr_busy, mshr_cnt
    );

endinterface

// File: rtl/l2_mshr_alloc_prio_enc.sv
// Lowest-set-bit priority encoder; idx_o is 0 when no bit is set.
module l2_mshr_prio_enc #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [WIDTH-1:0]     vec_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_WIDTH'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/l2_mshr_alloc.sv
// L2 MSHR owner: grants the lowest free entry, retires released entries and
// runs a drain handshake that blocks allocation until every entry has retired.
module l2_mshr_alloc
    import l2_mshr_alloc_pkg::*;
#(
    parameter int N_MSHR       = L2_N_MSHR,
    parameter int MSHR_BITS    = L2_MSHR_BITS,
    parameter int MSHR_BITS_P1 = L2_MSHR_BITS_P1
) (
    input  logic            clk,
    input  logic            rst,
    l2_mshr_alloc_if.slave  bus
);

    logic [N_MSHR-1:0]       busy_q, busy_d;
    logic [MSHR_BITS_P1-1:0] cnt_q, cnt_d;
    logic                    relErr_q, relErr_d;
    l2_mshr_alloc_state_t    state_q, state_d;

    logic [MSHR_BITS-1:0]    freeIdx;
    logic                    freeAny;
    logic                    allocGnt;
    logic                    relHit;
    logic                    relOk;
    logic [N_MSHR-1:0]       allocMask;
    logic [N_MSHR-1:0]       relMask;

    // Grant selection looks only at registered busy state, so a same-cycle
    // release never turns into a same-cycle grant.
    l2_mshr_prio_enc #(
        .WIDTH     (N_MSHR),
        .IDX_WIDTH (MSHR_BITS)
    ) u_prio_enc (
        .vec_i (~busy_q),
        .idx_o (freeIdx),
        .any_o (freeAny)
    );

    assign allocGnt  = bus.alloc_req & freeAny & (state_q == RUN) & ~bus.drain_req;
    assign relHit    = busy_q[bus.rel_idx];
    assign relOk     = bus.rel_valid & relHit;
    assign allocMask = allocGnt ? (N_MSHR'(1) << freeIdx) : '0;
    assign relMask   = relOk ? (N_MSHR'(1) << bus.rel_idx) : '0;

    always_comb begin
        busy_d   = (busy_q | allocMask) & ~relMask;
        cnt_d    = cnt_q - MSHR_BITS_P1'(allocGnt) + MSHR_BITS_P1'(relOk);
        relErr_d = bus.rel_valid & ~relHit;
    end

    // Dropping drain_req always returns to RUN, whether or not the drain finished.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!bus.drain_req)    state_d = RUN;
                else if (busy_q == '0) state_d = DONE;
            end
            DONE:    if (!bus.drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            cnt_q    <= MSHR_BITS_P1'(N_MSHR);
            relErr_q <= 1'b0;
            state_q  <= RUN;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            relErr_q <= relErr_d;
            state_q  <= state_d;
        end
    end

    assign bus.alloc_gnt  = allocGnt;
    assign bus.alloc_idx  = freeIdx;
    assign bus.rel_err    = relErr_q;
    assign bus.drain_done = (state_q == DONE);
    assign bus.mshr_busy  = busy_q;
    assign bus.mshr_cnt   = cnt_q;

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Bench for l2_mshr_alloc: a directed vector table for the corner cases,
// then randomized traffic compared against an entry-level reference model.
module tb_l2_mshr_alloc;
    import l2_mshr_alloc_pkg::*;

    localparam int N = L2_N_MSHR;

    typedef struct {
        logic       rst;
        logic       a;
        logic       rv;
        logic [1:0] ri;
        logic       d;
        logic       eg;
        logic [1:0] ei;
        logic [3:0] eb;
        logic [2:0] ec;
        logic       ee;
        logic       ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    l2_mshr_alloc_if bus ();

    l2_mshr_alloc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic r, a, rv, input logic [1:0] ri, input logic d,
                                input logic eg, input logic [1:0] ei, input logic [3:0] eb,
                                input logic [2:0] ec, input logic ee, ed);
        vec_t v;
        v.rst = r;  v.a = a;   v.rv = rv; v.ri = ri; v.d = d;
        v.eg = eg;  v.ei = ei; v.eb = eb; v.ec = ec; v.ee = ee; v.ed = ed;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic applyStimulus(input logic r, a, rv, input logic [1:0] ri, input logic d);
        @(negedge clk);
        rst           = r;
        bus.alloc_req = a;
        bus.rel_valid = rv;
        bus.rel_idx   = ri;
        bus.drain_req = d;
        #1;
    endtask

    task automatic checkAll(input string tag, input logic eg, input logic [1:0] ei, input logic [3:0] eb,
                            input logic [2:0] ec, input logic ee, ed);
        checkOutput({tag, " gnt"},  32'(bus.alloc_gnt),  32'(eg));
        checkOutput({tag, " idx"},  32'(bus.alloc_idx),  32'(ei));
        checkOutput({tag, " busy"}, 32'(bus.mshr_busy),  32'(eb));
        checkOutput({tag, " cnt"},  32'(bus.mshr_cnt),   32'(ec));
        checkOutput({tag, " err"},  32'(bus.rel_err),    32'(ee));
        checkOutput({tag, " done"}, 32'(bus.drain_done), 32'(ed));
    endtask

    // Reference model state: per-entry busy flags plus drain progress flags.
    bit mBusy[N];
    bit mErr;
    bit mDraining;
    bit mDrained;

    function automatic int mFreeCount();
        int c = 0;
        for (int i = 0; i < N; i++) if (!mBusy[i]) c++;
        return c;
    endfunction

    function automatic int mLowestFree();
        for (int i = 0; i < N; i++) if (!mBusy[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] mBusyVec();
        logic [3:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = mBusy[i];
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        bus.alloc_req = 1'b0;
        bus.rel_valid = 1'b0;
        bus.rel_idx   = '0;
        bus.drain_req = 1'b0;
        repeat (2) @(posedge clk);

        // Columns: rst a rv ri d | gnt idx busy cnt err done (outputs seen during that cycle).
        tbl.push_back(mk(0,0,0,0,0, 0,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,4'b0011,2,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,3,4'b0111,1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,4'b1111,0,0,0));
        tbl.push_back(mk(0,1,1,2,0, 0,0,4'b1111,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,4'b1011,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,4'b1111,0,0,0));
        tbl.push_back(mk(0,0,1,2,0, 0,0,4'b1111,0,0,0));
        tbl.push_back(mk(0,0,1,3,0, 0,2,4'b1011,1,0,0));
        tbl.push_back(mk(0,1,1,0,0, 1,2,4'b0011,2,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,4'b0110,2,0,0));
        tbl.push_back(mk(0,0,1,1,0, 0,0,4'b0110,2,0,0));
        tbl.push_back(mk(0,0,1,2,0, 0,0,4'b0100,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,0,1,3,0, 0,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,4'b0001,3,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,4'b0011,2,0,0));
        tbl.push_back(mk(0,0,1,1,0, 0,3,4'b0111,1,0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,1,4'b0101,2,0,0));
        tbl.push_back(mk(0,1,1,0,1, 0,1,4'b0101,2,0,0));
        tbl.push_back(mk(0,1,1,2,1, 0,0,4'b0100,3,0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,4'b0000,4,0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,0,4'b0000,4,0,1));
        tbl.push_back(mk(0,1,0,0,0, 1,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,4'b0001,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,4'b0011,2,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,3,4'b0111,1,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,4'b1111,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 0,0,4'b1110,1,0,0));
        tbl.push_back(mk(0,0,1,2,0, 0,0,4'b1100,2,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,4'b1000,3,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,4'b1000,3,0,0));
        tbl.push_back(mk(1,1,1,3,1, 0,0,4'b1000,3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,4'b0000,4,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,4'b0001,3,0,0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].a, tbl[i].rv, tbl[i].ri, tbl[i].d);
            checkAll($sformatf("row%0d", i), tbl[i].eg, tbl[i].ei, tbl[i].eb, tbl[i].ec, tbl[i].ee, tbl[i].ed);
        end

        // Randomized traffic against the reference model, starting from a fresh reset.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
        mErr = 1'b0; mDraining = 1'b0; mDrained = 1'b0;
        begin
            int   dHold = 0;
            logic r, a, rv, d, eg, relOk;
            logic [1:0] ri;
            int   lowest, freeBefore;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (dHold == 0 && $urandom_range(0, 40) == 0) dHold = $urandom_range(2, 14);
                d  = (dHold > 0);
                if (dHold > 0) dHold--;
                r  = ($urandom_range(0, 250) == 0);
                a  = ($urandom_range(0, 9) < 6);
                rv = ($urandom_range(0, 9) < 4);
                ri = 2'($urandom_range(0, N - 1));

                freeBefore = mFreeCount();
                lowest     = mLowestFree();
                eg = a && (freeBefore > 0) && !mDraining && !mDrained && !d;
                applyStimulus(r, a, rv, ri, d);
                checkAll($sformatf("rand%0d", cyc), eg, 2'(lowest), mBusyVec(),
                         3'(freeBefore), mErr, mDrained);

                if (r) begin
                    for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
                    mErr = 1'b0; mDraining = 1'b0; mDrained = 1'b0;
                end else begin
                    relOk = rv && mBusy[ri];
                    mErr  = rv && !mBusy[ri];
                    if (!d) begin
                        mDraining = 1'b0; mDrained = 1'b0;
                    end else if (!mDrained) begin
                        if (mDraining && freeBefore == N) begin
                            mDraining = 1'b0; mDrained = 1'b1;
                        end else begin
                            mDraining = 1'b1;
                        end
                    end
                    if (eg)    mBusy[lowest] = 1'b1;
                    if (relOk) mBusy[ri]     = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
